wb_stage: RTL and testbench

//  Write-back stage of the 5-stage MIPS pipeline; consumes the 123-bit MEM->WB bus.

---
 rtl/cpu_defs_pkg.sv | 58 +++++
 rtl/wb_cp0_regs.sv | 131 +++++++++++++
 rtl/wb_stage.sv | 157 +++++++++++++++
 tb/tb_wb_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
//==============================================================================
// Module      : cpu_defs_pkg
// Description : Shared definitions for the MIPS write-back stage: MEM->WB bus
//               layout, CP0 register addresses ({rd,sel}) and ExcCode values.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_defs_pkg;

   // Width of the MEM->WB bus. The top bit is reserved.
   localparam int c_bus_w = 123;

   // CP0 register addresses, encoded as {rd[4:0], sel[2:0]}.
   localparam logic [7:0] c_cp0_badvaddr = 8'h40;
   localparam logic [7:0] c_cp0_count    = 8'h48;
   localparam logic [7:0] c_cp0_compare  = 8'h58;
   localparam logic [7:0] c_cp0_status   = 8'h60;
   localparam logic [7:0] c_cp0_cause    = 8'h68;
   localparam logic [7:0] c_cp0_epc      = 8'h70;

   // Status bits software may change with mtc0: IM[7:0], EXL, IE.
   localparam logic [31:0] c_status_wmask = 32'h0000_FF03;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_OV   = 5'd12
   } exc_code_e;

   // MEM->WB bus, first member is the MSB.
   typedef struct packed {
      logic        rsvd;
      logic        rf_wen;
      logic [4:0]  rf_wdest;
      logic [31:0] mem_result;
      logic [31:0] lo_result;
      logic        hi_write;
      logic        lo_write;
      logic        mfhi;
      logic        mflo;
      logic        mtc0;
      logic        mfc0;
      logic [7:0]  cp0r_addr;
      logic        syscall;
      logic        eret;
      logic        fetch_error;
      logic        raddr_error;
      logic        waddr_error;
      logic        overflow;
      logic [31:0] pc;
   } mem_wb_bus_t;

endpackage

`default_nettype wire

// File: rtl/wb_cp0_regs.sv
//==============================================================================
// Module      : wb_cp0_regs
// Description : CP0 register file for the write-back stage (BadVAddr, Status,
//               Cause, EPC), with mtc0/mfc0 decode and exception/ERET updates.
//               Optional Count/Compare timer when WB_COUNT_EN is defined.
// Ports       : clk, rst         clock, async active-high reset
//               exc_i/exc_code_i  exception commit and its ExcCode
//               badv_we_i/badv_i  BadVAddr update on address faults
//               epc_i             PC of the faulting instruction
//               eret_i            ERET commit (clears EXL)
//               mtc0_i            mtc0 commit (already gated by exceptions)
//               addr_i/wdata_i    CP0 address and mtc0 data
//               rdata_o           mfc0 read data
//               epc_o             current EPC (ERET redirect target)
//               int_req_o         timer interrupt pending and enabled
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_cp0_regs
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_i,
   input  exc_code_e   exc_code_i,
   input  logic        badv_we_i,
   input  logic [31:0] badv_i,
   input  logic [31:0] epc_i,
   input  logic        eret_i,
   input  logic        mtc0_i,
   input  logic [7:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic [31:0] epc_o,
   output logic        int_req_o
);

   logic [31:0] badvaddr_q;
   logic [31:0] status_q;
   logic [31:0] epc_q;
   logic [4:0]  code_q;
   logic [1:0]  ip_q;

   logic        w_ti;
   logic [31:0] w_count;
   logic [31:0] w_compare;

   // Exception beats ERET beats mtc0; EPC is rewritten even when EXL is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         badvaddr_q <= '0;
         status_q   <= STATUS_RST;
         epc_q      <= '0;
         code_q     <= '0;
         ip_q       <= '0;
      end else if (exc_i) begin
         epc_q       <= epc_i;
         code_q      <= exc_code_i;
         status_q[1] <= 1'b1;
         if (badv_we_i) badvaddr_q <= badv_i;
      end else if (eret_i) begin
         status_q[1] <= 1'b0;
      end else if (mtc0_i) begin
         case (addr_i)
            c_cp0_status: status_q <= (status_q & ~c_status_wmask) | (wdata_i & c_status_wmask);
            c_cp0_cause:  ip_q     <= wdata_i[9:8];
            c_cp0_epc:    epc_q    <= wdata_i;
            default:      ;
         endcase
      end
   end

`ifdef WB_COUNT_EN
   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic        half_q;
   logic        ti_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         compare_q <= '0;
         half_q    <= 1'b0;
         ti_q      <= 1'b0;
      end else begin
         half_q <= ~half_q;
         // A software write to Count overrides the tick.
         if (mtc0_i && addr_i == c_cp0_count) count_q <= wdata_i;
         else if (half_q)                      count_q <= count_q + 32'd1;
         // Writing Compare acknowledges the timer, even on a match cycle.
         if (mtc0_i && addr_i == c_cp0_compare) begin
            compare_q <= wdata_i;
            ti_q      <= 1'b0;
         end else if (count_q == compare_q) begin
            ti_q <= 1'b1;
         end
      end
   end

   assign w_ti      = ti_q;
   assign w_count   = count_q;
   assign w_compare = compare_q;
   assign int_req_o = ti_q & status_q[0] & status_q[15] & ~status_q[1];
`else
   assign w_ti      = 1'b0;
   assign w_count   = '0;
   assign w_compare = '0;
   assign int_req_o = 1'b0;
`endif

   always_comb begin
      rdata_o = '0;
      case (addr_i)
         c_cp0_badvaddr: rdata_o = badvaddr_q;
         c_cp0_count:    rdata_o = w_count;
         c_cp0_compare:  rdata_o = w_compare;
         c_cp0_status:   rdata_o = status_q;
         c_cp0_cause:    rdata_o = {1'b0, w_ti, 20'd0, ip_q, 1'b0, code_q, 2'b00};
         c_cp0_epc:      rdata_o = epc_q;
         default:        rdata_o = '0;
      endcase
   end

   assign epc_o = epc_q;

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
//==============================================================================
// Module      : wb_stage
// Description : Write-back stage of the 5-stage MIPS pipeline. Commits
//               register-file writes, owns HI/LO and CP0, prioritises precise
//               exceptions and ERET, and issues a registered one-cycle cancel
//               with a redirect PC. Define WB_COUNT_EN to add the Count/Compare
//               timer and its interrupt.
// Ports       : clk, rst             clock, async active-high reset
//               WB_valid             valid instruction in WB
//               MEM_WB_bus_r [122:0] MEM->WB bus
//               WB_badvaddr  [31:0]  data address of the memory op
//               WB_over, WB_allow_in handshake
//               rf_wen/rf_wdest/rf_wdata  regfile write port
//               WB_wdest             destination for hazard detection
//               cancel, exc_pc       registered flush pulse and redirect PC
//               WB_pc                PC in WB
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_stage
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               WB_valid,
   input  logic [c_bus_w-1:0] MEM_WB_bus_r,
   input  logic [31:0]        WB_badvaddr,
   output logic               WB_over,
   output logic               WB_allow_in,
   output logic               rf_wen,
   output logic [4:0]         rf_wdest,
   output logic [31:0]        rf_wdata,
   output logic [4:0]         WB_wdest,
   output logic               cancel,
   output logic [31:0]        exc_pc,
   output logic [31:0]        WB_pc
);

   mem_wb_bus_t w_bus;
   logic        w_unused_rsvd;
   logic        w_commit;
   logic        w_exc;
   logic        w_eret;
   exc_code_e   w_exc_code;
   logic        w_badv_we;
   logic [31:0] w_badv;
   logic        w_int_req;
   logic [31:0] w_cp0_rdata;
   logic [31:0] w_epc;

   logic [31:0] hi_q, lo_q;
   logic        cancel_q, cancel_d;
   logic [31:0] exc_pc_q, exc_pc_d;

   assign w_bus         = mem_wb_bus_t'(MEM_WB_bus_r);
   assign w_unused_rsvd = w_bus.rsvd;

   // Anything sitting in WB during the flush cycle is a squashed instruction.
   assign w_commit = WB_valid & ~cancel_q;
   assign w_exc    = w_commit & (w_int_req | w_bus.fetch_error | w_bus.overflow |
                                 w_bus.syscall | w_bus.raddr_error | w_bus.waddr_error);
   assign w_eret   = w_commit & w_bus.eret & ~w_exc;

   always_comb begin
      w_exc_code = EXC_INT;
      w_badv_we  = 1'b0;
      w_badv     = WB_badvaddr;
      if (w_int_req) begin
         w_exc_code = EXC_INT;
      end else if (w_bus.fetch_error) begin
         w_exc_code = EXC_ADEL;
         w_badv_we  = 1'b1;
         w_badv     = w_bus.pc;
      end else if (w_bus.overflow) begin
         w_exc_code = EXC_OV;
      end else if (w_bus.syscall) begin
         w_exc_code = EXC_SYS;
      end else if (w_bus.raddr_error) begin
         w_exc_code = EXC_ADEL;
         w_badv_we  = 1'b1;
      end else if (w_bus.waddr_error) begin
         w_exc_code = EXC_ADES;
         w_badv_we  = 1'b1;
      end
   end

   wb_cp0_regs #(
      .STATUS_RST (STATUS_RST)
   ) u_cp0 (
      .clk        (clk),
      .rst        (rst),
      .exc_i      (w_exc),
      .exc_code_i (w_exc_code),
      .badv_we_i  (w_badv_we),
      .badv_i     (w_badv),
      .epc_i      (w_bus.pc),
      .eret_i     (w_eret),
      .mtc0_i     (w_commit & w_bus.mtc0 & ~w_exc),
      .addr_i     (w_bus.cp0r_addr),
      .wdata_i    (w_bus.mem_result),
      .rdata_o    (w_cp0_rdata),
      .epc_o      (w_epc),
      .int_req_o  (w_int_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (w_commit & w_bus.hi_write & ~w_exc) hi_q <= w_bus.mem_result;
         if (w_commit & w_bus.lo_write & ~w_exc) lo_q <= w_bus.lo_result;
      end
   end

   // ERET redirects to the EPC held before this edge.
   always_comb begin
      cancel_d = w_exc | w_eret;
      exc_pc_d = exc_pc_q;
      if (w_exc)       exc_pc_d = EXC_VECTOR;
      else if (w_eret) exc_pc_d = w_epc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cancel_q <= 1'b0;
         exc_pc_q <= '0;
      end else begin
         cancel_q <= cancel_d;
         exc_pc_q <= exc_pc_d;
      end
   end

   // HI/LO reads see the pre-edge value; no same-cycle forwarding.
   always_comb begin
      rf_wdata = w_bus.mem_result;
      if (w_bus.mfhi)      rf_wdata = hi_q;
      else if (w_bus.mflo) rf_wdata = lo_q;
      else if (w_bus.mfc0) rf_wdata = w_cp0_rdata;
   end

   assign rf_wen      = w_commit & w_bus.rf_wen & ~w_exc & ~rst;
   assign rf_wdest    = w_bus.rf_wdest;
   assign WB_wdest    = w_bus.rf_wdest & {5{WB_valid}};
   assign WB_over     = WB_valid;
   assign WB_allow_in = ~cancel_q;
   assign cancel      = cancel_q;
   assign exc_pc      = exc_pc_q;
   assign WB_pc       = w_bus.pc;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
//==============================================================================
// Module      : tb_wb_stage
// Description : Directed self-checking bench for wb_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         WB_valid;
   logic [122:0] MEM_WB_bus_r;
   logic [31:0]  WB_badvaddr;
   logic         WB_over, WB_allow_in, rf_wen, cancel;
   logic [4:0]   rf_wdest, WB_wdest;
   logic [31:0]  rf_wdata, exc_pc, WB_pc;

   logic         b_rf_wen, b_hiw, b_low, b_mfhi, b_mflo, b_mtc0, b_mfc0;
   logic         b_sys, b_eret, b_fe, b_re, b_we, b_ov;
   logic [4:0]   b_wdest;
   logic [7:0]   b_addr;
   logic [31:0]  b_mem, b_lo, b_pc;

   int vec = 0;
   int err = 0;

   localparam logic [31:0] c_vec = 32'hBFC0_0380;
`ifdef WB_COUNT_EN
   localparam logic [31:0] c_ti = 32'h4000_0000;
`else
   localparam logic [31:0] c_ti = 32'h0;
`endif

   assign MEM_WB_bus_r = {1'b0, b_rf_wen, b_wdest, b_mem, b_lo, b_hiw, b_low, b_mfhi, b_mflo,
                          b_mtc0, b_mfc0, b_addr, b_sys, b_eret, b_fe, b_re, b_we, b_ov, b_pc};

   wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .WB_valid     (WB_valid),
      .MEM_WB_bus_r (MEM_WB_bus_r),
      .WB_badvaddr  (WB_badvaddr),
      .WB_over      (WB_over),
      .WB_allow_in  (WB_allow_in),
      .rf_wen       (rf_wen),
      .rf_wdest     (rf_wdest),
      .rf_wdata     (rf_wdata),
      .WB_wdest     (WB_wdest),
      .cancel       (cancel),
      .exc_pc       (exc_pc),
      .WB_pc        (WB_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      WB_valid = 0; WB_badvaddr = '0;
      b_rf_wen = 0; b_hiw = 0; b_low = 0; b_mfhi = 0; b_mflo = 0; b_mtc0 = 0; b_mfc0 = 0;
      b_sys = 0; b_eret = 0; b_fe = 0; b_re = 0; b_we = 0; b_ov = 0;
      b_wdest = '0; b_addr = '0; b_mem = '0; b_lo = '0; b_pc = '0;
   endtask

   task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
      clr(); WB_valid = 1; b_mtc0 = 1; b_addr = a; b_mem = d;
      tick(); clr();
   endtask

   // sel: 0 = mfc0, 1 = mfhi, 2 = mflo
   task automatic rd(input int sel, input logic [7:0] a, output logic [31:0] v);
      clr(); WB_valid = 1; b_addr = a;
      b_mfc0 = (sel == 0); b_mfhi = (sel == 1); b_mflo = (sel == 2);
      #1 v = rf_wdata;
      tick(); clr();
   endtask

   task automatic test_reset();
      logic [31:0] v;
      clr(); WB_valid = 1; b_rf_wen = 1; #1;
      vec++; if (rf_wen !== 1'b0) begin err++; $display("FAIL rst_rf_wen: got %b want 0", rf_wen); end
      vec++; if (cancel !== 1'b0) begin err++; $display("FAIL rst_cancel: got %b want 0", cancel); end
      vec++; if (exc_pc !== 32'h0) begin err++; $display("FAIL rst_exc_pc: got %h want 0", exc_pc); end
      tick(); rst = 0; clr(); tick();
      rd(0, 8'h60, v);
      vec++; if (v !== 32'h0040_0000) begin err++; $display("FAIL rst_status: got %h want 00400000", v); end
      rd(1, 8'h0, v);
      vec++; if (v !== 32'h0) begin err++; $display("FAIL rst_hi: got %h want 0", v); end
      rd(0, 8'h70, v);
      vec++; if (v !== 32'h0) begin err++; $display("FAIL rst_epc: got %h want 0", v); end
      rd(0, 8'h68, v);
      vec++; if (v !== c_ti) begin err++; $display("FAIL rst_cause: got %h want %h", v, c_ti); end
   endtask

   task automatic test_rf_write();
      clr(); WB_valid = 1; b_rf_wen = 1; b_wdest = 5'd5; b_mem = 32'h1234_5678; b_pc = 32'h8000_0004; #1;
      vec++; if ({rf_wen, rf_wdest, WB_wdest} !== {1'b1, 5'd5, 5'd5}) begin err++; $display("FAIL rf_ctl: got %b/%d/%d want 1/5/5", rf_wen, rf_wdest, WB_wdest); end
      vec++; if (rf_wdata !== 32'h1234_5678) begin err++; $display("FAIL rf_wdata: got %h want 12345678", rf_wdata); end
      vec++; if ({WB_over, WB_allow_in, WB_pc} !== {2'b11, 32'h8000_0004}) begin err++; $display("FAIL rf_misc: got %b%b %h want 11 80000004", WB_over, WB_allow_in, WB_pc); end
      WB_valid = 0; #1;
      vec++; if ({rf_wen, WB_wdest} !== 6'd0) begin err++; $display("FAIL rf_invalid: got %b/%d want 0/0", rf_wen, WB_wdest); end
      tick(); clr();
   endtask

   task automatic test_hilo();
      logic [31:0] v;
      clr(); WB_valid = 1; b_hiw = 1; b_low = 1; b_mfhi = 1; b_rf_wen = 1; b_mem = 32'h1; b_lo = 32'h2; #1;
      vec++; if (rf_wdata !== 32'h0) begin err++; $display("FAIL hilo_nofwd: got %h want 0", rf_wdata); end
      tick();
      rd(1, 8'h0, v);
      vec++; if (v !== 32'h1) begin err++; $display("FAIL mfhi: got %h want 1", v); end
      rd(2, 8'h0, v);
      vec++; if (v !== 32'h2) begin err++; $display("FAIL mflo: got %h want 2", v); end
   endtask

   task automatic test_syscall();
      logic [31:0] v;
      clr(); WB_valid = 1; b_sys = 1; b_pc = 32'hBFC0_0100; b_rf_wen = 1; b_hiw = 1; b_mem = 32'hDEAD; #1;
      vec++; if (rf_wen !== 1'b0) begin err++; $display("FAIL sys_rf_wen: got %b want 0", rf_wen); end
      tick();
      vec++; if ({cancel, WB_allow_in} !== 2'b10) begin err++; $display("FAIL sys_cancel: got %b%b want 10", cancel, WB_allow_in); end
      vec++; if (exc_pc !== c_vec) begin err++; $display("FAIL sys_exc_pc: got %h want %h", exc_pc, c_vec); end
      clr(); WB_valid = 1; b_rf_wen = 1; b_hiw = 1; b_mem = 32'h5555; #1;
      vec++; if (rf_wen !== 1'b0) begin err++; $display("FAIL cancel_drop: got %b want 0", rf_wen); end
      tick(); clr();
      vec++; if (cancel !== 1'b0) begin err++; $display("FAIL cancel_pulse: got %b want 0", cancel); end
      rd(1, 8'h0, v);
      vec++; if (v !== 32'h1) begin err++; $display("FAIL sys_hi_kept: got %h want 1", v); end
      rd(0, 8'h70, v);
      vec++; if (v !== 32'hBFC0_0100) begin err++; $display("FAIL sys_epc: got %h want bfc00100", v); end
      rd(0, 8'h68, v);
      vec++; if (v !== (32'h20 | c_ti)) begin err++; $display("FAIL sys_cause: got %h want %h", v, 32'h20 | c_ti); end
      rd(0, 8'h60, v);
      vec++; if (v !== 32'h0040_0002) begin err++; $display("FAIL sys_status: got %h want 00400002", v); end
   endtask

   task automatic test_eret(input logic [31:0] epc);
      logic [31:0] v;
      clr(); WB_valid = 1; b_eret = 1; b_pc = 32'h8000_0200;
      tick(); clr();
      vec++; if ({cancel, exc_pc} !== {1'b1, epc}) begin err++; $display("FAIL eret: got %b %h want 1 %h", cancel, exc_pc, epc); end
      tick();
      rd(0, 8'h60, v);
      vec++; if (v !== 32'h0040_0000) begin err++; $display("FAIL eret_status: got %h want 00400000", v); end
   endtask

   // One faulting commit, then the flush cycle; returns Cause, BadVAddr, EPC.
   task automatic fault(input logic [3:0] f, input logic [31:0] pc, input logic [31:0] bad,
                        output logic [31:0] cause, output logic [31:0] badv, output logic [31:0] epc);
      clr(); WB_valid = 1; {b_fe, b_ov, b_re, b_we} = f; b_pc = pc; WB_badvaddr = bad;
      tick(); clr(); tick();
      rd(0, 8'h68, cause); rd(0, 8'h40, badv); rd(0, 8'h70, epc);
   endtask

   task automatic test_priority();
      logic [31:0] c, b, e;
      fault(4'b0110, 32'h8000_0010, 32'h1234_5678, c, b, e);
      vec++; if ({c, b, e} !== {32'h30 | c_ti, 32'h0, 32'h8000_0010}) begin err++; $display("FAIL prio_ov: got %h %h %h want %h 0 80000010", c, b, e, 32'h30 | c_ti); end
      fault(4'b0010, 32'h8000_0020, 32'hA000_0004, c, b, e);
      vec++; if ({c, b, e} !== {32'h10 | c_ti, 32'hA000_0004, 32'h8000_0020}) begin err++; $display("FAIL adel: got %h %h %h want %h a0000004 80000020", c, b, e, 32'h10 | c_ti); end
      fault(4'b0001, 32'h8000_0024, 32'hA000_0008, c, b, e);
      vec++; if ({c, b} !== {32'h14 | c_ti, 32'hA000_0008}) begin err++; $display("FAIL ades: got %h %h want %h a0000008", c, b, 32'h14 | c_ti); end
      fault(4'b1111, 32'h8000_0031, 32'hA000_000C, c, b, e);
      vec++; if ({c, b} !== {32'h10 | c_ti, 32'h8000_0031}) begin err++; $display("FAIL fetch: got %h %h want %h 80000031", c, b, 32'h10 | c_ti); end
   endtask

   task automatic test_mtc0();
      logic [31:0] v;
      mtc0(8'h60, 32'hFFFF_FFFF); rd(0, 8'h60, v);
      vec++; if (v !== 32'h0040_FF03) begin err++; $display("FAIL st_mask: got %h want 0040ff03", v); end
      mtc0(8'h60, 32'h0); rd(0, 8'h60, v);
      vec++; if (v !== 32'h0040_0000) begin err++; $display("FAIL st_clr: got %h want 00400000", v); end
      mtc0(8'h68, 32'hFFFF_FFFF); rd(0, 8'h68, v);
      vec++; if (v !== (32'h310 | c_ti)) begin err++; $display("FAIL cause_mask: got %h want %h", v, 32'h310 | c_ti); end
      mtc0(8'h68, 32'h0); mtc0(8'h40, 32'h5A5A_5A5A); rd(0, 8'h40, v);
      vec++; if (v !== 32'h8000_0031) begin err++; $display("FAIL badv_ro: got %h want 80000031", v); end
      mtc0(8'h08, 32'hFFFF_FFFF); rd(0, 8'h08, v);
      vec++; if (v !== 32'h0) begin err++; $display("FAIL unk_addr: got %h want 0", v); end
`ifndef WB_COUNT_EN
      mtc0(8'h48, 32'hFFFF_FFFF); rd(0, 8'h48, v);
      vec++; if (v !== 32'h0) begin err++; $display("FAIL count_absent: got %h want 0", v); end
`endif
      clr(); WB_valid = 1; b_mtc0 = 1; b_addr = 8'h70; b_mem = 32'hFFFF_0000; b_sys = 1; b_pc = 32'h8000_0040;
      tick(); clr(); tick();
      rd(0, 8'h70, v);
      vec++; if (v !== 32'h8000_0040) begin err++; $display("FAIL mtc0_vs_exc: got %h want 80000040", v); end
      test_eret(32'h8000_0040);
   endtask

`ifdef WB_COUNT_EN
   task automatic test_count();
      logic [31:0] v;
      mtc0(8'h58, 32'd4); mtc0(8'h48, 32'd0); mtc0(8'h60, 32'h8001);
      repeat (20) tick();
      clr(); WB_valid = 1; b_rf_wen = 1; b_pc = 32'h8000_0100; #1;
      vec++; if (rf_wen !== 1'b0) begin err++; $display("FAIL int_rf_wen: got %b want 0", rf_wen); end
      tick(); clr();
      vec++; if ({cancel, exc_pc} !== {1'b1, c_vec}) begin err++; $display("FAIL int_cancel: got %b %h want 1 %h", cancel, exc_pc, c_vec); end
      tick();
      rd(0, 8'h68, v);
      vec++; if (v !== 32'h4000_0000) begin err++; $display("FAIL int_cause: got %h want 40000000", v); end
      rd(0, 8'h70, v);
      vec++; if (v !== 32'h8000_0100) begin err++; $display("FAIL int_epc: got %h want 80000100", v); end
      mtc0(8'h58, 32'h0001_0000); rd(0, 8'h68, v);
      vec++; if (v !== 32'h0) begin err++; $display("FAIL ti_clear: got %h want 0", v); end
   endtask
`endif

   task automatic test_reset_midrun();
      logic [31:0] v;
      clr(); WB_valid = 1; b_sys = 1; b_pc = 32'h8000_0300;
      tick();
      clr(); WB_valid = 1; b_rf_wen = 1; rst = 1; #1;
      vec++; if ({cancel, rf_wen, exc_pc} !== 34'h0) begin err++; $display("FAIL mid_rst: got %b %b %h want 0 0 0", cancel, rf_wen, exc_pc); end
      tick(); rst = 0; clr();
      rd(0, 8'h60, v);
      vec++; if (v !== 32'h0040_0000) begin err++; $display("FAIL mid_rst_status: got %h want 00400000", v); end
      rd(1, 8'h0, v);
      vec++; if (v !== 32'h0) begin err++; $display("FAIL mid_rst_hi: got %h want 0", v); end
      rd(2, 8'h0, v);
      vec++; if (v !== 32'h0) begin err++; $display("FAIL mid_rst_lo: got %h want 0", v); end
   endtask

   initial begin
      rst = 1;
      clr();
      repeat (3) tick();
      test_reset();
      test_rf_write();
      test_hilo();
      test_syscall();
      test_eret(32'hBFC0_0100);
      test_priority();
      test_mtc0();
`ifdef WB_COUNT_EN
      test_count();
`endif
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

`default_nettype wire
